// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode enum, result width and the golden reference model.
// Imported by both the ALU and its result checker so they agree on encoding.
package alu_pkg;

    localparam int ALU_OPND_W = 4;
    localparam int ALU_RES_W  = 5;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_t;

    // One in-flight operation as tracked by the checker pipeline.
    typedef struct packed {
        logic                   valid;
        alu_op_t                op;
        logic [ALU_OPND_W-1:0]  a;
        logic [ALU_OPND_W-1:0]  b;
        logic [ALU_RES_W-1:0]   exp;
    } alu_rec_t;

    // Bit 4 is the carry for ADD and the borrow for SUB (mod-32 wrap).
    function automatic logic [ALU_RES_W-1:0] alu_golden(
        input logic [ALU_OPND_W-1:0] a,
        input logic [ALU_OPND_W-1:0] b,
        input alu_op_t               op
    );
        logic [ALU_RES_W-1:0] res;
        case (op)
            OP_ADD:  res = {1'b0, a} + {1'b0, b};
            OP_SUB:  res = {1'b0, a} - {1'b0, b};
            OP_AND:  res = {1'b0, a & b};
            OP_OR:   res = {1'b0, a | b};
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_chk_pipe.sv
// LATENCY-deep shift register of checker records; the tail lines up with the ALU output C.
// Reset discards every in-flight record.
module alu_chk_pipe
    import alu_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  alu_rec_t din,
    output alu_rec_t dout
);

    alu_rec_t stages [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < LATENCY; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[LATENCY-1];

endmodule

// File: rtl/alu_result_checker.sv
// Golden-model monitor for the ALU: delays expected results by LATENCY, compares with C,
// counts passes/fails (saturating) and latches the first mismatch.
module alu_result_checker
    import alu_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [ALU_OPND_W-1:0] A,
    input  logic [ALU_OPND_W-1:0] B,
    input  logic [1:0]            opcode,
    input  logic [ALU_RES_W-1:0]  C,
    input  logic                  clr,
    output logic [CNT_W-1:0]      pass_cnt,
    output logic [CNT_W-1:0]      fail_cnt,
    output logic                  err,
    output logic                  ff_valid,
    output logic [1:0]            ff_op,
    output logic [ALU_OPND_W-1:0] ff_a,
    output logic [ALU_OPND_W-1:0] ff_b,
    output logic [ALU_RES_W-1:0]  ff_exp,
    output logic [ALU_RES_W-1:0]  ff_got
);

    typedef enum logic {
        S_OK   = 1'b0,
        S_FAIL = 1'b1
    } chk_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    alu_rec_t   issue_rec;
    alu_rec_t   tail_rec;
    chk_state_t state, next_state, state_base;
    logic       match, mismatch, capture;
    logic [CNT_W-1:0] pass_base, fail_base, pass_next, fail_next;

    always_comb begin
        issue_rec.valid = in_valid;
        issue_rec.op    = alu_op_t'(opcode);
        issue_rec.a     = A;
        issue_rec.b     = B;
        issue_rec.exp   = alu_golden(A, B, alu_op_t'(opcode));
    end

    alu_chk_pipe #(.LATENCY(LATENCY)) u_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  (issue_rec),
        .dout (tail_rec)
    );

    // clr is applied first, so a comparison in the same cycle counts against cleared state.
    always_comb begin
        match      = tail_rec.valid && (tail_rec.exp == C);
        mismatch   = tail_rec.valid && (tail_rec.exp != C);
        state_base = clr ? S_OK : state;
        pass_base  = clr ? '0 : pass_cnt;
        fail_base  = clr ? '0 : fail_cnt;
        next_state = state_base;
        capture    = 1'b0;
        pass_next  = pass_base;
        fail_next  = fail_base;
        if (match && (pass_base != CNT_MAX)) begin
            pass_next = pass_base + 1'b1;
        end
        if (mismatch && (fail_base != CNT_MAX)) begin
            fail_next = fail_base + 1'b1;
        end
        case (state_base)
            S_OK: begin
                if (mismatch) begin
                    next_state = S_FAIL;
                    capture    = 1'b1;
                end
            end
            S_FAIL:  next_state = S_FAIL;
            default: next_state = S_OK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_OK;
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            state    <= next_state;
            pass_cnt <= pass_next;
            fail_cnt <= fail_next;
        end
    end

    // First-mismatch capture: loaded only on the S_OK to S_FAIL transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff_valid <= 1'b0;
            ff_op    <= '0;
            ff_a     <= '0;
            ff_b     <= '0;
            ff_exp   <= '0;
            ff_got   <= '0;
        end else if (capture) begin
            ff_valid <= 1'b1;
            ff_op    <= tail_rec.op;
            ff_a     <= tail_rec.a;
            ff_b     <= tail_rec.b;
            ff_exp   <= tail_rec.exp;
            ff_got   <= C;
        end else if (clr) begin
            ff_valid <= 1'b0;
            ff_op    <= '0;
            ff_a     <= '0;
            ff_b     <= '0;
            ff_exp   <= '0;
            ff_got   <= '0;
        end
    end

    assign err = (state == S_FAIL);

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: a LATENCY=1 instance with 3-bit counters for
// saturation, and a LATENCY=3 instance for the reset-discard scenario.
module tb_alu_result_checker;
    import alu_pkg::*;

    logic       clk;
    logic       rst1, rst3;
    logic       in_valid, clr;
    logic [3:0] a_in, b_in;
    logic [1:0] opcode;
    logic [4:0] c_in;

    logic [2:0] pass1, fail1;
    logic       err1, ffv1;
    logic [1:0] ffop1;
    logic [3:0] ffa1, ffb1;
    logic [4:0] ffexp1, ffgot1;

    logic [15:0] pass3, fail3;
    logic        err3, ffv3;
    logic [1:0]  ffop3;
    logic [3:0]  ffa3, ffb3;
    logic [4:0]  ffexp3, ffgot3;

    int assertCount;
    int failCount;

    alu_result_checker #(.LATENCY(1), .CNT_W(3)) dut (
        .clk(clk), .rst(rst1), .in_valid(in_valid), .A(a_in), .B(b_in),
        .opcode(opcode), .C(c_in), .clr(clr),
        .pass_cnt(pass1), .fail_cnt(fail1), .err(err1), .ff_valid(ffv1),
        .ff_op(ffop1), .ff_a(ffa1), .ff_b(ffb1), .ff_exp(ffexp1), .ff_got(ffgot1)
    );

    alu_result_checker #(.LATENCY(3)) dut3 (
        .clk(clk), .rst(rst3), .in_valid(in_valid), .A(a_in), .B(b_in),
        .opcode(opcode), .C(c_in), .clr(clr),
        .pass_cnt(pass3), .fail_cnt(fail3), .err(err3), .ff_valid(ffv3),
        .ff_op(ffop3), .ff_a(ffa3), .ff_b(ffb3), .ff_exp(ffexp3), .ff_got(ffgot3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [3:0] b,
                                 input logic [1:0] op, input logic [4:0] c, input logic cl);
        in_valid = v;
        a_in     = a;
        b_in     = b;
        opcode   = op;
        c_in     = c;
        clr      = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst1 = 1'b1;
        rst3 = 1'b1;
        applyStimulus(1'b1, 4'h3, 4'h3, 2'b00, 5'h00, 1'b0);
        applyStimulus(1'b1, 4'h3, 4'h3, 2'b00, 5'h00, 1'b0);
        checkOutput("reset pass_cnt", 32'(pass1), 32'd0);
        checkOutput("reset fail_cnt", 32'(fail1), 32'd0);
        checkOutput("reset err",      32'(err1),  32'd0);
        checkOutput("reset ff_valid", 32'(ffv1),  32'd0);
        checkOutput("reset ff_exp",   32'(ffexp1), 32'd0);
        rst1 = 1'b0;

        $display("[TB] basic ADD");
        applyStimulus(1'b1, 4'h2, 4'h1, 2'b00, 5'h00, 1'b0);
        checkOutput("issue edge pass_cnt", 32'(pass1), 32'd0);
        applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 5'h03, 1'b0);
        checkOutput("add pass_cnt", 32'(pass1), 32'd1);
        checkOutput("add fail_cnt", 32'(fail1), 32'd0);
        checkOutput("add err",      32'(err1),  32'd0);

        $display("[TB] width and borrow boundaries back-to-back");
        applyStimulus(1'b1, 4'hF, 4'hF, 2'b00, 5'h00, 1'b0);
        applyStimulus(1'b1, 4'h4, 4'h3, 2'b01, 5'h1E, 1'b0);
        applyStimulus(1'b1, 4'h3, 4'h4, 2'b01, 5'h01, 1'b0);
        applyStimulus(1'b1, 4'hF, 4'hA, 2'b11, 5'h1F, 1'b0);
        applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 5'h0F, 1'b0);
        checkOutput("boundary pass_cnt", 32'(pass1), 32'd5);
        checkOutput("boundary fail_cnt", 32'(fail1), 32'd0);

        $display("[TB] first mismatch capture");
        applyStimulus(1'b1, 4'h9, 4'h6, 2'b10, 5'h0F, 1'b0);
        applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 5'h01, 1'b0);
        checkOutput("mm fail_cnt", 32'(fail1),  32'd1);
        checkOutput("mm err",      32'(err1),   32'd1);
        checkOutput("mm ff_valid", 32'(ffv1),   32'd1);
        checkOutput("mm ff_op",    32'(ffop1),  32'd2);
        checkOutput("mm ff_a",     32'(ffa1),   32'd9);
        checkOutput("mm ff_b",     32'(ffb1),   32'd6);
        checkOutput("mm ff_exp",   32'(ffexp1), 32'd0);
        checkOutput("mm ff_got",   32'(ffgot1), 32'd1);
        applyStimulus(1'b1, 4'h1, 4'h1, 2'b00, 5'h00, 1'b0);
        applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 5'h03, 1'b0);
        checkOutput("mm2 fail_cnt", 32'(fail1),  32'd2);
        checkOutput("mm2 ff_a",     32'(ffa1),   32'd9);
        checkOutput("mm2 ff_got",   32'(ffgot1), 32'd1);
        checkOutput("mm2 pass_cnt", 32'(pass1),  32'd5);

        $display("[TB] idle cycles with random C");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'(($urandom)), 4'(($urandom)), 2'(($urandom)),
                          5'(($urandom)), 1'b0);
        end
        checkOutput("idle pass_cnt", 32'(pass1), 32'd5);
        checkOutput("idle fail_cnt", 32'(fail1), 32'd2);

        $display("[TB] pass counter saturation");
        applyStimulus(1'b1, 4'h1, 4'h2, 2'b00, 5'h00, 1'b0);
        applyStimulus(1'b1, 4'h5, 4'h3, 2'b10, 5'h03, 1'b0);
        checkOutput("sat pass_cnt 6", 32'(pass1), 32'd6);
        applyStimulus(1'b1, 4'h0, 4'h0, 2'b11, 5'h01, 1'b0);
        checkOutput("sat pass_cnt 7", 32'(pass1), 32'd7);
        applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 5'h00, 1'b0);
        checkOutput("sat pass_cnt hold", 32'(pass1), 32'd7);

        $display("[TB] clr coincident with comparison");
        applyStimulus(1'b1, 4'h6, 4'h2, 2'b01, 5'h00, 1'b0);
        applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 5'h04, 1'b1);
        checkOutput("clr match pass_cnt", 32'(pass1), 32'd1);
        checkOutput("clr match fail_cnt", 32'(fail1), 32'd0);
        checkOutput("clr match err",      32'(err1),  32'd0);
        checkOutput("clr match ff_valid", 32'(ffv1),  32'd0);
        checkOutput("clr match ff_a",     32'(ffa1),  32'd0);
        applyStimulus(1'b1, 4'h7, 4'h7, 2'b10, 5'h00, 1'b0);
        applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 5'h00, 1'b1);
        checkOutput("clr mm pass_cnt", 32'(pass1),  32'd0);
        checkOutput("clr mm fail_cnt", 32'(fail1),  32'd1);
        checkOutput("clr mm err",      32'(err1),   32'd1);
        checkOutput("clr mm ff_exp",   32'(ffexp1), 32'd7);
        checkOutput("clr mm ff_got",   32'(ffgot1), 32'd0);
        checkOutput("clr mm ff_a",     32'(ffa1),   32'd7);

        $display("[TB] LATENCY=3 reset discards in-flight op");
        rst3 = 1'b0;
        applyStimulus(1'b1, 4'h2, 4'h2, 2'b00, 5'h04, 1'b0);
        applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 5'h04, 1'b0);
        rst3 = 1'b1;
        applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 5'h04, 1'b0);
        rst3 = 1'b0;
        applyStimulus(1'b1, 4'h3, 4'h1, 2'b00, 5'h04, 1'b0);
        checkOutput("lat3 after rst pass_cnt", 32'(pass3), 32'd0);
        applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 5'h04, 1'b0);
        applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 5'h04, 1'b0);
        checkOutput("lat3 early pass_cnt", 32'(pass3), 32'd0);
        checkOutput("lat3 early fail_cnt", 32'(fail3), 32'd0);
        applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 5'h04, 1'b0);
        checkOutput("lat3 pass_cnt", 32'(pass3), 32'd1);
        checkOutput("lat3 fail_cnt", 32'(fail3), 32'd0);
        checkOutput("lat3 err",      32'(err3),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
